reg_dump_monitor: RTL and testbench
===================================

# reg_dump_monitor

Debug/observation block attached beside the multi-cycle CPU. On each entry of the control unit into a trigger state, it walks the architectural register file through a dedicated read port. It emits every (index, value) pair plus the captured instruction as a valid/ready stream, so a bench or on-chip logger can consume it. It also provides a cycle watchdog that flags a run exceeding a cycle budget, replacing fixed-time bench termination.

## Interface
Parameters:
- XLEN, 32, data width of registers and instruction
- NREGS, 32, number of registers walked (≥2)
- AW, $clog2(NREGS), register index width
- STATE_W, 5, control-unit state width
- TRIG_STATE, 5'd16, state value that triggers a dump
- TIMEOUT_CYCLES, 28, watchdog budget in cycles; 0 disables the watchdog

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- cpu_state  in  STATE_W  current control-unit state
- instr  in  XLEN  current instruction word
- rf_raddr  out  AW  register-file read address
- rf_rdata  in  XLEN  register-file read data, combinational from rf_raddr
- dump_valid  out  1  stream entry valid
- dump_ready  in  1  consumer accepts entry
- dump_idx  out  AW  register index of entry
- dump_data  out  XLEN  register value
- dump_instr  out  XLEN  instruction latched at trigger
- dump_last  out  1  entry is index NREGS-1
- busy  out  1  dump in progress
- dump_count  out  16  completed dumps, wraps at 2^16
- overrun  out  1  sticky: trigger arrived while busy
- timeout  out  1  sticky: watchdog expired

## Operation
- Trigger = rising edge of (cpu_state == TRIG_STATE), registered match_q. Remaining in TRIG_STATE does not retrigger.
- FSM states: IDLE, READ, SEND.
- IDLE: on trigger, latch instr into dump_instr, idx←0, go to READ.
- READ: rf_raddr=idx; register rf_rdata into dump_data, idx into dump_idx; go to SEND.
- SEND: dump_valid=1; outputs stable until handshake (valid&ready).
  - On handshake with idx==NREGS-1: dump_count+1, go to IDLE.
  - On handshake otherwise: idx+1, go to READ.
- busy = (state != IDLE).
- rf_raddr = idx in all states (0 in IDLE).
- Trigger while busy: ignored; overrun←1 (sticky until reset). Current dump continues.
- Trigger coinciding with the final handshake: treated as busy (overrun set, not started).
- Watchdog: 32-bit counter increments every cycle after reset release, saturating at TIMEOUT_CYCLES. timeout←1 the cycle the count reaches TIMEOUT_CYCLES. Counting is independent of dump activity.
- dump_count wraps 0xFFFF→0.

## Timing
- Reset (rst=0, async) values:
  - state=IDLE, idx=0, match_q=0
  - dump_valid=0, dump_idx=0, dump_data=0, dump_instr=0, dump_last=0
  - busy=0, dump_count=0, overrun=0, timeout=0, watchdog count=0
- Reset mid-dump aborts immediately; no partial completion is counted.
- Trigger edge sampled at clock k → READ at k+1 → dump_valid high from k+2.
- Each entry takes min 2 cycles (READ + SEND). A full dump with dump_ready tied high takes 2·NREGS cycles.
- dump_ready low stalls SEND indefinitely with no loss.
- dump_last = dump_valid && dump_idx==NREGS-1.

## Configuration
- REG_DUMP_SKIP_ZERO_EN defined:
  - In READ, if rf_rdata==0 and idx≠NREGS-1, emit no entry; idx+1 and stay in READ (1 cycle per skipped register).
  - Index NREGS-1 is always emitted so dump_last terminates every dump.
- Undefined: every index 0..NREGS-1 is emitted, including zero values.

## Structure
- Package cpu_dbg_pkg:
  - FSM state enum (IDLE/READ/SEND)
  - default trigger state constant 5'd16
  - dump_count width constant 16
- One sub-module, cycle_watchdog: saturating counter plus sticky timeout, parameterised by TIMEOUT_CYCLES.

## Test plan
- Register model r[i]=i·0x11; pulse cpu_state=16 for 3 cycles, dump_ready=1 → exactly 32 entries, idx 0..31, data i·0x11, dump_last only on idx 31, dump_count=1, first valid 2 cycles after the edge.
- Same stimulus, dump_ready toggled 1-0-0-1 → entries unchanged and in order; outputs stable during stalls; total 32 handshakes.
- Second trigger edge at entry idx 5 → overrun=1, dump completes with 32 entries, dump_count=1.
- Defaults (TIMEOUT_CYCLES=28), no triggers → timeout=0 at cycle 27, 1 at cycle 28, remains 1; TIMEOUT_CYCLES=0 → never asserts.
- rst pulled low at idx 10 → all outputs to reset values asynchronously; after release, a new trigger restarts from idx 0.
- REG_DUMP_SKIP_ZERO_EN with r[0]=0, r[3]=0xDEADBEEF, all others 0 → entries idx 3 (0xDEADBEEF) and idx 31 (0, dump_last=1) only.

Source files
------------

// File: rtl/cpu_dbg_pkg.sv
// Shared types and constants for the CPU debug observation blocks.
// Holds the register-dump FSM encoding and default trigger settings.
package cpu_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2
  } dump_state_e;

  localparam logic [4:0] TRIG_STATE_DEF = 5'd16;
  localparam int unsigned DUMP_CNT_W = 16;

endpackage

// File: rtl/cycle_watchdog.sv
// Saturating cycle counter with a sticky timeout flag.
// A budget of zero disables the flag entirely.
module cycle_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 28
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic timeout_o
);

  localparam logic [31:0] LIM = 32'(TIMEOUT_CYCLES);

  logic [31:0] cnt_q, cnt_d;
  logic        to_q, to_d;

  // Count up until the budget is reached, flag on arrival
  always_comb begin
    cnt_d = cnt_q;
    to_d  = to_q;
    if (LIM != 32'd0 && cnt_q != LIM) begin
      cnt_d = cnt_q + 32'd1;
      if (cnt_d == LIM) to_d = 1'b1;
    end
  end

  // Counter and sticky flag registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign timeout_o = to_q;

endmodule

// File: rtl/reg_dump_monitor.sv
// Walks the register file on entry to a trigger state and streams it out.
// Define REG_DUMP_SKIP_ZERO_EN to drop zero-valued registers (last always sent).
module reg_dump_monitor
  import cpu_dbg_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned NREGS          = 32,
  parameter int unsigned AW             = $clog2(NREGS),
  parameter int unsigned STATE_W        = 5,
  parameter logic [STATE_W-1:0] TRIG_STATE = STATE_W'(TRIG_STATE_DEF),
  parameter int unsigned TIMEOUT_CYCLES = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STATE_W-1:0]    cpu_state,
  input  logic [XLEN-1:0]       instr,
  output logic [AW-1:0]         rf_raddr,
  input  logic [XLEN-1:0]       rf_rdata,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [AW-1:0]         dump_idx,
  output logic [XLEN-1:0]       dump_data,
  output logic [XLEN-1:0]       dump_instr,
  output logic                  dump_last,
  output logic                  busy,
  output logic [DUMP_CNT_W-1:0] dump_count,
  output logic                  overrun,
  output logic                  timeout
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  dump_state_e          state_q, state_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic                 match_q, match_d;
  logic [AW-1:0]        didx_q, didx_d;
  logic [XLEN-1:0]      data_q, data_d;
  logic [XLEN-1:0]      ins_q, ins_d;
  logic [DUMP_CNT_W-1:0] cnt_q, cnt_d;
  logic                 ovr_q, ovr_d;
  logic                 trig;
  logic                 hs;

  assign match_d    = (cpu_state == TRIG_STATE);
  assign trig       = match_d && !match_q;
  assign dump_valid = (state_q == ST_SEND);
  assign hs         = dump_valid && dump_ready;

  // Next-state logic for the dump walk
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    didx_d  = didx_q;
    data_d  = data_q;
    ins_d   = ins_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (trig) begin
          ins_d   = instr;
          idx_d   = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
`ifdef REG_DUMP_SKIP_ZERO_EN
        if (rf_rdata == '0 && idx_q != LAST_IDX) begin
          idx_d = idx_q + AW'(1);
        end else begin
          data_d  = rf_rdata;
          didx_d  = idx_q;
          state_d = ST_SEND;
        end
`else
        data_d  = rf_rdata;
        didx_d  = idx_q;
        state_d = ST_SEND;
`endif
      end
      ST_SEND: begin
        if (hs) begin
          if (idx_q == LAST_IDX) begin
            cnt_d   = cnt_q + DUMP_CNT_W'(1);
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = ST_READ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (trig && state_q != ST_IDLE) ovr_d = 1'b1;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      match_q <= 1'b0;
      didx_q  <= '0;
      data_q  <= '0;
      ins_q   <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      match_q <= match_d;
      didx_q  <= didx_d;
      data_q  <= data_d;
      ins_q   <= ins_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rf_raddr   = idx_q;
  assign dump_idx   = didx_q;
  assign dump_data  = data_q;
  assign dump_instr = ins_q;
  assign dump_last  = dump_valid && (didx_q == LAST_IDX);
  assign busy       = (state_q != ST_IDLE);
  assign dump_count = cnt_q;
  assign overrun    = ovr_q;

  cycle_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_i    (clk),
    .rst_ni   (rst),
    .timeout_o(timeout)
  );

endmodule

// File: tb/tb_reg_dump_monitor.sv
// Scoreboard bench for reg_dump_monitor against a list-based dump model.
// Honours REG_DUMP_SKIP_ZERO_EN in the model when the macro is defined.
module tb_reg_dump_monitor;

  localparam int N  = 32;
  localparam int WD = 28;
  localparam logic [4:0] TRIG = 5'd16;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    logic [31:0] ins;
    logic        last;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  cpu_state;
  logic [31:0] instr;
  logic [31:0] rf [N];
  logic        dump_ready;

  logic [4:0]  rf_raddr, rf_raddr0;
  logic [31:0] rf_rdata, rf_rdata0;
  logic        dump_valid, dump_last, busy, overrun, timeout;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data, dump_instr;
  logic [15:0] dump_count;

  logic        v0, l0, b0, o0, timeout0;
  logic [4:0]  i0;
  logic [31:0] d0, n0;
  logic [15:0] c0;

  ent_t        sbq[$];
  int          checks = 0;
  int          failures = 0;
  int          n_pop = 0;
  int          exp_cnt = 0;
  logic        exp_ovr = 1'b0;
  int          wd = 0;
  logic        stall_pend = 1'b0;
  logic [69:0] hold;

  always #5 clk = ~clk;

  assign rf_rdata  = rf[rf_raddr];
  assign rf_rdata0 = rf[rf_raddr0];

  reg_dump_monitor u_dut (
    .clk(clk), .rst(rst), .cpu_state(cpu_state), .instr(instr),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data),
    .dump_instr(dump_instr), .dump_last(dump_last),
    .busy(busy), .dump_count(dump_count),
    .overrun(overrun), .timeout(timeout)
  );

  reg_dump_monitor #(.TIMEOUT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .cpu_state(cpu_state), .instr(instr),
    .rf_raddr(rf_raddr0), .rf_rdata(rf_rdata0),
    .dump_valid(v0), .dump_ready(dump_ready),
    .dump_idx(i0), .dump_data(d0),
    .dump_instr(n0), .dump_last(l0),
    .busy(b0), .dump_count(c0),
    .overrun(o0), .timeout(timeout0)
  );

  function automatic void chk(string nm, logic [95:0] act, logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  // cycles since reset release
  always @(posedge clk or negedge rst) begin
    if (!rst) wd <= 0;
    else wd <= wd + 1;
  end

  // monitor: pops expected entries on each handshake
  always @(negedge clk) begin
    ent_t e;
    if (rst !== 1'b1) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend)
        chk("stall_hold", {dump_valid, dump_idx, dump_data, dump_instr}, hold);
      if (dump_valid && dump_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_entry actual_idx=%0d required=none", dump_idx);
        end else begin
          e = sbq.pop_front();
          chk("entry_idx", dump_idx, e.idx);
          chk("entry_data", dump_data, e.data);
          chk("entry_instr", dump_instr, e.ins);
          chk("entry_last", dump_last, e.last);
          n_pop++;
        end
        stall_pend = 1'b0;
      end else if (dump_valid) begin
        stall_pend = 1'b1;
        hold = {dump_valid, dump_idx, dump_data, dump_instr};
      end else begin
        stall_pend = 1'b0;
      end
      chk("timeout", timeout, (wd >= WD));
      chk("timeout_disabled", timeout0, 1'b0);
    end
  end

  function automatic void set_rf(input int mode);
    for (int i = 0; i < N; i++) begin
      case (mode)
        0: rf[i] = i * 32'h11;
        1: rf[i] = ($urandom % 4 == 0) ? 32'h0 : $urandom;
        default: rf[i] = (i == 3) ? 32'hDEAD_BEEF : 32'h0;
      endcase
    end
  endfunction

  task automatic chk_reset_vals();
    chk("rst_valid", dump_valid, 1'b0);
    chk("rst_idx", dump_idx, 5'd0);
    chk("rst_data", dump_data, 32'd0);
    chk("rst_instr", dump_instr, 32'd0);
    chk("rst_last", dump_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", dump_count, 16'd0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_raddr", rf_raddr, 5'd0);
  endtask

  // rmode: 0 ready high, 1 pattern 1-0-0-1, 2 random
  task automatic run_dump(input int hold_c, input int reiss_c,
                          input int rmode, input int abort_n);
    ent_t e;
    int   c;
    int   fv;
    bit   done;
    c    = 0;
    done = 0;
    instr = $urandom;
    for (int i = 0; i < N; i++) begin
`ifdef REG_DUMP_SKIP_ZERO_EN
      if (rf[i] == 32'h0 && i != N - 1) continue;
`endif
      e.idx  = 5'(i);
      e.data = rf[i];
      e.ins  = instr;
      e.last = (i == N - 1);
      sbq.push_back(e);
    end
    fv = 2 + int'(sbq[0].idx);
    n_pop = 0;
    cpu_state = TRIG;
    dump_ready = (rmode == 2) ? 1'($urandom % 2) : 1'b1;
    while (!done) begin
      @(posedge clk);
      #1;
      c++;
      if (c == 1) chk("busy_start", busy, 1'b1);
      if (c == fv - 1) chk("no_early_valid", dump_valid, 1'b0);
      if (c == fv) chk("first_valid", dump_valid, 1'b1);
      if (c == hold_c) cpu_state = 5'd0;
      if (c == reiss_c) begin
        cpu_state = TRIG;
        exp_ovr = 1'b1;
      end
      if (c == reiss_c + 1) cpu_state = 5'd0;
      case (rmode)
        0: dump_ready = 1'b1;
        1: dump_ready = (c % 4 == 0) || (c % 4 == 3);
        default: dump_ready = 1'($urandom % 2);
      endcase
      if (abort_n >= 0 && n_pop == abort_n) begin
        #3;
        rst = 1'b0;
        #1;
        chk_reset_vals();
        sbq.delete();
        exp_cnt = 0;
        exp_ovr = 1'b0;
        cpu_state = 5'd0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        return;
      end
      if (sbq.size() == 0 && !busy) done = 1;
      if (c > 3000) begin
        checks++;
        failures++;
        $display("FAIL dump_budget actual=%0d_left required=0", sbq.size());
        sbq.delete();
        done = 1;
      end
    end
    exp_cnt++;
    chk("dump_count", dump_count, 16'(exp_cnt));
    chk("overrun", overrun, exp_ovr);
    chk("idle_raddr", rf_raddr, 5'd0);
  endtask

  initial begin
    rst = 1'b0;
    cpu_state = 5'd0;
    instr = 32'h0;
    dump_ready = 1'b0;
    set_rf(0);
    #3;
    chk_reset_vals();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("idle_valid", dump_valid, 1'b0);

    set_rf(0);
    run_dump(3, -10, 0, -1);
    run_dump(3, -10, 1, -1);
    set_rf(1);
    run_dump(3, 20, 2, -1);
    set_rf(1);
    run_dump(2, -10, 2, -1);
    set_rf(0);
    run_dump(3, -10, 0, 10);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("post_rst_overrun", overrun, 1'b0);
    set_rf(0);
    run_dump(3, -10, 2, -1);
    set_rf(2);
    run_dump(3, -10, 0, -1);
    for (int k = 0; k < 3; k++) begin
      set_rf(1);
      run_dump(1 + k, -10, 2, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
